sap_control_sequencer: RTL and testbench

- Microcoded control unit for the 8-bit bus machine.
- Sits upstream of the accumulator, the add/sub unit, PC, MAR, RAM, IR, B and output registers.
- Steps a T-state counter and decodes the held opcode plus CF/ZF into the per-cycle control word.
- The control word includes accumulator load/enable_output and the ALU's active-low output enable and sub.

---
 rtl/sap_control_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_sap_control_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sap_control_sequencer.sv
// T-state sequencer and microcode decoder for the 8-bit bus machine.
// Define COND_JUMP_EN to decode JC (7) and JZ (8); otherwise they behave as NOP.
module sap_control_sequencer #(
    parameter int unsigned T_MAX = 5,
    parameter int unsigned OPW   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] instr,
    input  logic       cf,
    input  logic       zf,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_load,
    output logic       ram_out,
    output logic       ram_load,
    output logic       ir_load,
    output logic       ir_out,
    output logic       a_load,
    output logic       a_out,
    output logic       b_load,
    output logic       alu_oe_n,
    output logic       sub,
    output logic       out_load,
    output logic       halted,
    output logic [2:0] tstate
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5
    } tstate_e;

    typedef struct packed {
        logic pc_out;
        logic pc_inc;
        logic pc_load;
        logic mar_load;
        logic ram_out;
        logic ram_load;
        logic ir_load;
        logic ir_out;
        logic a_load;
        logic a_out;
        logic b_load;
        logic alu_oe;
        logic sub;
        logic out_load;
    } ctrl_t;

    tstate_e        tstate_q;
    logic           halted_q;
    logic [OPW-1:0] opcode;
    logic           last_step;
    logic           hlt_step;
    logic           active;
    ctrl_t          cw;
    ctrl_t          cw_gated;

    assign opcode = instr[7 -: OPW];

    // Operand nibble only reaches the bus through the IR itself.
    logic unused_operand;
    assign unused_operand = ^instr[7-OPW:0];
`ifndef COND_JUMP_EN
    logic unused_flags;
    assign unused_flags = cf ^ zf;
`endif

    always_comb begin
        cw        = '0;
        last_step = 1'b0;
        hlt_step  = 1'b0;
        case (tstate_q)
            T0: begin
                cw.pc_out   = 1'b1;
                cw.mar_load = 1'b1;
            end
            T1: begin
                cw.ram_out = 1'b1;
                cw.ir_load = 1'b1;
                cw.pc_inc  = 1'b1;
            end
            T2: begin
                last_step = 1'b1;
                case (opcode)
                    4'h1, 4'h2, 4'h3, 4'h4: begin
                        cw.ir_out   = 1'b1;
                        cw.mar_load = 1'b1;
                        last_step   = 1'b0;
                    end
                    4'h5: begin
                        cw.ir_out = 1'b1;
                        cw.a_load = 1'b1;
                    end
                    4'h6: begin
                        cw.ir_out  = 1'b1;
                        cw.pc_load = 1'b1;
                    end
`ifdef COND_JUMP_EN
                    4'h7: begin
                        cw.ir_out  = cf;
                        cw.pc_load = cf;
                    end
                    4'h8: begin
                        cw.ir_out  = zf;
                        cw.pc_load = zf;
                    end
`endif
                    4'hE: begin
                        cw.a_out    = 1'b1;
                        cw.out_load = 1'b1;
                    end
                    4'hF:    hlt_step = 1'b1;
                    default: ;
                endcase
            end
            T3: begin
                last_step = 1'b1;
                case (opcode)
                    4'h1: begin
                        cw.ram_out = 1'b1;
                        cw.a_load  = 1'b1;
                    end
                    4'h2, 4'h3: begin
                        cw.ram_out = 1'b1;
                        cw.b_load  = 1'b1;
                        cw.sub     = (opcode == 4'h3);
                        last_step  = 1'b0;
                    end
                    4'h4: begin
                        cw.a_out    = 1'b1;
                        cw.ram_load = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                last_step = 1'b1;
                if (opcode == 4'h2 || opcode == 4'h3) begin
                    cw.alu_oe = 1'b1;
                    cw.a_load = 1'b1;
                    cw.sub    = (opcode == 4'h3);
                end
            end
            default: last_step = 1'b1;
        endcase
    end

    assign active   = ~rst & ena & ~halted_q;
    assign cw_gated = active ? cw : '0;

    assign pc_out   = cw_gated.pc_out;
    assign pc_inc   = cw_gated.pc_inc;
    assign pc_load  = cw_gated.pc_load;
    assign mar_load = cw_gated.mar_load;
    assign ram_out  = cw_gated.ram_out;
    assign ram_load = cw_gated.ram_load;
    assign ir_load  = cw_gated.ir_load;
    assign ir_out   = cw_gated.ir_out;
    assign a_load   = cw_gated.a_load;
    assign a_out    = cw_gated.a_out;
    assign b_load   = cw_gated.b_load;
    assign alu_oe_n = ~cw_gated.alu_oe;
    assign sub      = cw_gated.sub;
    assign out_load = cw_gated.out_load;
    assign halted   = halted_q;
    assign tstate   = tstate_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tstate_q <= T0;
            halted_q <= 1'b0;
        end else if (ena && !halted_q) begin
            if (last_step || tstate_q == tstate_e'(3'(T_MAX))) begin
                tstate_q <= T0;
            end else begin
                tstate_q <= tstate_e'(tstate_q + 3'd1);
            end
            if (hlt_step) begin
                halted_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Scoreboard bench for sap_control_sequencer: per-instruction microprogram model,
// directed sequences followed by randomized opcodes, flags, enables and resets.
module tb_sap_control_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic [7:0] instr = 8'h00;
    logic       cf = 1'b0;
    logic       zf = 1'b0;
    logic       pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load, ir_load, ir_out;
    logic       a_load, a_out, b_load, alu_oe_n, sub, out_load, halted;
    logic [2:0] tstate;

    always #5 clk = ~clk;

    sap_control_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .instr    (instr),
        .cf       (cf),
        .zf       (zf),
        .pc_out   (pc_out),
        .pc_inc   (pc_inc),
        .pc_load  (pc_load),
        .mar_load (mar_load),
        .ram_out  (ram_out),
        .ram_load (ram_load),
        .ir_load  (ir_load),
        .ir_out   (ir_out),
        .a_load   (a_load),
        .a_out    (a_out),
        .b_load   (b_load),
        .alu_oe_n (alu_oe_n),
        .sub      (sub),
        .out_load (out_load),
        .halted   (halted),
        .tstate   (tstate)
    );

    localparam logic [13:0] PC_OUT   = 14'd1 << 13;
    localparam logic [13:0] PC_INC   = 14'd1 << 12;
    localparam logic [13:0] PC_LOAD  = 14'd1 << 11;
    localparam logic [13:0] MAR_LOAD = 14'd1 << 10;
    localparam logic [13:0] RAM_OUT  = 14'd1 << 9;
    localparam logic [13:0] RAM_LOAD = 14'd1 << 8;
    localparam logic [13:0] IR_LOAD  = 14'd1 << 7;
    localparam logic [13:0] IR_OUT   = 14'd1 << 6;
    localparam logic [13:0] A_LOAD   = 14'd1 << 5;
    localparam logic [13:0] A_OUT    = 14'd1 << 4;
    localparam logic [13:0] B_LOAD   = 14'd1 << 3;
    localparam logic [13:0] ALU_OE   = 14'd1 << 2;
    localparam logic [13:0] SUB      = 14'd1 << 1;
    localparam logic [13:0] OUT_LOAD = 14'd1;

    typedef struct packed {
        logic [13:0] word;
        logic [2:0]  ts;
        logic        hlt;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [13:0] prog[0:5];
    int          prog_len;
    int          m_step = 0;
    bit          m_halted = 1'b0;

    // Whole instruction as a list of control words: fetch pair, then execute steps.
    task automatic load_program(input logic [7:0] ins, input logic c, input logic z);
        logic [3:0] op;
        op = ins[7:4];
        for (int i = 0; i < 6; i++) prog[i] = '0;
        prog[0]  = PC_OUT | MAR_LOAD;
        prog[1]  = RAM_OUT | IR_LOAD | PC_INC;
        prog_len = 3;
        case (op)
            4'h1: begin prog[2] = IR_OUT | MAR_LOAD; prog[3] = RAM_OUT | A_LOAD; prog_len = 4; end
            4'h2: begin
                prog[2] = IR_OUT | MAR_LOAD; prog[3] = RAM_OUT | B_LOAD;
                prog[4] = ALU_OE | A_LOAD; prog_len = 5;
            end
            4'h3: begin
                prog[2] = IR_OUT | MAR_LOAD; prog[3] = RAM_OUT | B_LOAD | SUB;
                prog[4] = ALU_OE | A_LOAD | SUB; prog_len = 5;
            end
            4'h4: begin prog[2] = IR_OUT | MAR_LOAD; prog[3] = A_OUT | RAM_LOAD; prog_len = 4; end
            4'h5: prog[2] = IR_OUT | A_LOAD;
            4'h6: prog[2] = IR_OUT | PC_LOAD;
`ifdef COND_JUMP_EN
            4'h7: prog[2] = c ? (IR_OUT | PC_LOAD) : 14'd0;
            4'h8: prog[2] = z ? (IR_OUT | PC_LOAD) : 14'd0;
`endif
            4'hE: prog[2] = A_OUT | OUT_LOAD;
            default: ;
        endcase
    endtask

    task automatic cycle(input logic r, input logic e, input logic [7:0] ins,
                         input logic c, input logic z);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; ena = e; instr = ins; cf = c; zf = z;
        load_program(ins, c, z);
        x.ts   = 3'(m_step);
        x.hlt  = m_halted;
        x.word = (r || !e || m_halted) ? 14'd0 : prog[m_step];
        sb.push_back(x);
        if (r) begin
            m_step = 0; m_halted = 1'b0;
        end else if (e && !m_halted) begin
            if (ins[7:4] == 4'hF && m_step == 2) m_halted = 1'b1;
            m_step++;
            if (m_step >= prog_len) m_step = 0;
        end
    endtask

    task automatic run_instr(input logic [7:0] ins, input logic c, input logic z);
        int n;
        n = 0;
        do begin
            cycle(1'b0, 1'b1, ins, c, z);
            n++;
        end while (m_step != 0 && n < 8);
    endtask

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endfunction

    exp_t        mon_x;
    logic [13:0] mon_word;
    int          mon_drivers;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_x    = sb.pop_front();
            mon_word = {pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load, ir_load, ir_out,
                        a_load, a_out, b_load, ~alu_oe_n, sub, out_load};
            check("control_word", 32'(mon_word), 32'(mon_x.word));
            check("tstate", 32'(tstate), 32'(mon_x.ts));
            check("halted", 32'(halted), 32'(mon_x.hlt));
            mon_drivers = $countones({pc_out, ram_out, ir_out, a_out, ~alu_oe_n});
            vectors++;
            if (mon_drivers > 1) begin
                miscompares++;
                $display("FAIL bus_drivers at t=%0t: %0d asserted, at most 1 allowed",
                         $time, mon_drivers);
            end
        end
    end

    initial begin
        logic [7:0] cur_ins;
        logic       cur_c, cur_z, r, e;
        int         halt_cycles;

        @(posedge clk);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        run_instr(8'h2A, 1'b0, 1'b0);
        run_instr(8'h3C, 1'b0, 1'b0);
        run_instr(8'h57, 1'b0, 1'b0);

        // Reset arriving at T3 of an ADD.
        repeat (3) cycle(1'b0, 1'b1, 8'h2A, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h2A, 1'b0, 1'b0);
        run_instr(8'h2A, 1'b0, 1'b0);

        // LDA frozen at T3 for four cycles.
        repeat (3) cycle(1'b0, 1'b1, 8'h1B, 1'b0, 1'b0);
        repeat (4) cycle(1'b0, 1'b0, 8'h1B, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h1B, 1'b0, 1'b0);

        run_instr(8'h74, 1'b1, 1'b0);
        run_instr(8'h74, 1'b0, 1'b1);
        run_instr(8'h84, 1'b0, 1'b1);
        run_instr(8'h84, 1'b1, 1'b0);
        run_instr(8'h4D, 1'b0, 1'b0);
        run_instr(8'h63, 1'b0, 1'b0);
        run_instr(8'hE0, 1'b0, 1'b0);
        run_instr(8'h00, 1'b0, 1'b0);
        run_instr(8'h9F, 1'b0, 1'b0);
        run_instr(8'hD1, 1'b0, 1'b0);

        run_instr(8'hF0, 1'b0, 1'b0);
        repeat (20) cycle(1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_instr(8'h57, 1'b0, 1'b0);

        cur_ins = 8'h00; cur_c = 1'b0; cur_z = 1'b0; halt_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            if (m_step == 0) begin
                cur_ins = 8'($urandom);
                cur_c   = 1'($urandom);
                cur_z   = 1'($urandom);
            end
            r = ($urandom_range(0, 99) < 2);
            e = ($urandom_range(0, 99) < 85);
            if (m_halted) halt_cycles++;
            if (halt_cycles >= 12) begin
                r = 1'b1;
                halt_cycles = 0;
            end
            cycle(r, e, cur_ins, cur_c, cur_z);
        end

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
